// File: rtl/sdp_chn_out_wait_pkg.sv
// Shared constants and helpers for the multi-channel SDP output write-wait datapath.
package sdp_chn_out_wait_pkg;

  localparam int unsigned NCHN_DEF  = 2;
  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned DEPTH_DEF = 2;
  localparam int unsigned STAT_W    = 16;

  // Occupancy counter width: must represent 0..DEPTH inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sdp_chn_out_fifo.sv
// Single-channel DEPTH x DW output FIFO with registered storage and no bypass.
module sdp_chn_out_fifo
  import sdp_chn_out_wait_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned CW   = cnt_w(DEPTH),
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          prdy,
  output logic [CW-1:0] cnt,
  output logic          pvld,
  output logic [DW-1:0] pd
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop;

  assign pvld = (cnt_q != '0);
  assign pd   = mem_q[rptr_q];
  assign cnt  = cnt_q;
  assign pop  = pvld & prdy;

  // Next-state: write at wptr, read at rptr, both wrapping at DEPTH-1; push is pre-qualified by the caller.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q] = wdata;
      wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // State registers; reset clears storage so pd reads zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/sdp_chn_out_wait_dp_mc.sv
// Multi-channel SDP output write-wait datapath: per-channel completion hold plus output FIFO.
// Optional stall statistics counter enabled by SDP_CHN_OUT_WAIT_DP_STAT_EN.
module sdp_chn_out_wait_dp_mc
  import sdp_chn_out_wait_pkg::*;
#(
  parameter int unsigned NCHN  = NCHN_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic [NCHN-1:0]      chn_out_rsci_oswt,
  input  logic [NCHN*DW-1:0]   chn_out_rsci_idat,
  input  logic                 chn_out_rsci_bdwt,
  output logic [NCHN-1:0]      chn_out_rsci_bawt,
  output logic [NCHN-1:0]      chn_out_rsci_wen_comp,
  output logic [NCHN-1:0]      chn_out_pvld,
  input  logic [NCHN-1:0]      chn_out_prdy,
  output logic [NCHN*DW-1:0]   chn_out_pd
`ifdef SDP_CHN_OUT_WAIT_DP_STAT_EN
  ,output logic [STAT_W-1:0]   chn_out_stall_cnt
`endif
);

  localparam int unsigned CW = cnt_w(DEPTH);

  logic [NCHN-1:0] bcwt_q, bcwt_d;
  logic [NCHN-1:0] push;
  logic [NCHN-1:0] full;

  for (genvar g = 0; g < NCHN; g++) begin : g_chn
    logic [CW-1:0] cnt;

    assign full[g] = (cnt == CW'(DEPTH));

    sdp_chn_out_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (nvdla_core_clk),
      .rst_n (nvdla_core_rstn),
      .push  (push[g]),
      .wdata (chn_out_rsci_idat[g*DW +: DW]),
      .prdy  (chn_out_prdy[g]),
      .cnt   (cnt),
      .pvld  (chn_out_pvld[g]),
      .pd    (chn_out_pd[g*DW +: DW])
    );
  end

  // Handshake: a held completion or a full FIFO blocks the push; bawt reports push or held completion.
  always_comb begin
    push                  = chn_out_rsci_oswt & ~bcwt_q & ~full;
    chn_out_rsci_bawt     = push | bcwt_q;
    chn_out_rsci_wen_comp = ~chn_out_rsci_oswt | chn_out_rsci_bawt;
    bcwt_d                = chn_out_rsci_bawt & ~{NCHN{chn_out_rsci_bdwt}};
  end

  // Completion-hold flops.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) bcwt_q <= '0;
    else                  bcwt_q <= bcwt_d;
  end

`ifdef SDP_CHN_OUT_WAIT_DP_STAT_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles in which any channel stalls the core.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|(chn_out_rsci_oswt & ~chn_out_rsci_wen_comp)) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // Stall counter register.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) stall_cnt_q <= '0;
    else                  stall_cnt_q <= stall_cnt_d;
  end

  assign chn_out_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sdp_chn_out_wait_dp_mc.sv
// Directed self-checking bench for sdp_chn_out_wait_dp_mc (NCHN=2, DW=8, DEPTH=2).
module tb_sdp_chn_out_wait_dp_mc;

  localparam int unsigned NCHN  = 2;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCHN-1:0]      oswt;
  logic [NCHN*DW-1:0]   idat;
  logic                 bdwt;
  logic [NCHN-1:0]      bawt;
  logic [NCHN-1:0]      wen_comp;
  logic [NCHN-1:0]      pvld;
  logic [NCHN-1:0]      prdy;
  logic [NCHN*DW-1:0]   pd;
`ifdef SDP_CHN_OUT_WAIT_DP_STAT_EN
  logic [15:0]          stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sdp_chn_out_wait_dp_mc #(
    .NCHN  (NCHN),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rstn       (rst_n),
    .chn_out_rsci_oswt     (oswt),
    .chn_out_rsci_idat     (idat),
    .chn_out_rsci_bdwt     (bdwt),
    .chn_out_rsci_bawt     (bawt),
    .chn_out_rsci_wen_comp (wen_comp),
    .chn_out_pvld          (pvld),
    .chn_out_prdy          (prdy),
    .chn_out_pd            (pd)
`ifdef SDP_CHN_OUT_WAIT_DP_STAT_EN
    ,.chn_out_stall_cnt    (stall_cnt)
`endif
  );

  // Advance one clock; inputs are then changed and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; oswt = '0; idat = '0; bdwt = 1'b0; prdy = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    tests++; if (bawt !== 2'b00) begin fails++; $display("FAIL reset_bawt got=%b exp=00", bawt); end
    tests++; if (wen_comp !== 2'b11) begin fails++; $display("FAIL reset_wen_comp got=%b exp=11", wen_comp); end
    tests++; if (pvld !== 2'b00) begin fails++; $display("FAIL reset_pvld got=%b exp=00", pvld); end
    tests++; if (pd !== 16'h0000) begin fails++; $display("FAIL reset_pd got=%h exp=0000", pd); end
  endtask

  task automatic test_completion_hold();
    oswt = 2'b01; idat = 16'h00A5; bdwt = 1'b0; prdy = 2'b00;
    #1;
    tests++; if (bawt[0] !== 1'b1) begin fails++; $display("FAIL hold_c1_bawt got=%b exp=1", bawt[0]); end
    tests++; if (pvld[0] !== 1'b0) begin fails++; $display("FAIL hold_c1_pvld got=%b exp=0", pvld[0]); end
    for (int c = 2; c <= 4; c++) begin
      tick();
      if (c == 4) begin bdwt = 1'b1; #1; end
      tests++; if (bawt[0] !== 1'b1) begin fails++; $display("FAIL hold_c%0d_bawt got=%b exp=1", c, bawt[0]); end
      tests++; if (wen_comp[0] !== 1'b1) begin fails++; $display("FAIL hold_c%0d_wen got=%b exp=1", c, wen_comp[0]); end
      tests++; if (pvld[0] !== 1'b1 || pd[7:0] !== 8'hA5) begin
        fails++; $display("FAIL hold_c%0d_out got=%b/%h exp=1/a5", c, pvld[0], pd[7:0]);
      end
    end
    tick();
    oswt = 2'b00; bdwt = 1'b0; #1;
    tests++; if (bawt[0] !== 1'b0) begin fails++; $display("FAIL hold_cleared_bawt got=%b exp=0", bawt[0]); end
    prdy = 2'b01;
    tick();
    prdy = 2'b00; #1;
    tests++; if (pvld[0] !== 1'b0) begin fails++; $display("FAIL hold_single_push pvld got=%b exp=0", pvld[0]); end
  endtask

  task automatic test_backpressure();
    logic [7:0] wr [3];
    wr[0] = 8'h11; wr[1] = 8'h22; wr[2] = 8'h33;
    bdwt = 1'b1; prdy = 2'b00;
    for (int k = 0; k < 2; k++) begin
      oswt = 2'b10; idat = {wr[k], 8'h00}; #1;
      tests++; if (wen_comp[1] !== 1'b1) begin fails++; $display("FAIL bp_wr%0d_wen got=%b exp=1", k, wen_comp[1]); end
      tick();
    end
    idat = {wr[2], 8'h00}; #1;
    for (int k = 0; k < 2; k++) begin
      tests++; if (wen_comp[1] !== 1'b0 || bawt[1] !== 1'b0) begin
        fails++; $display("FAIL bp_full%0d wen/bawt got=%b/%b exp=0/0", k, wen_comp[1], bawt[1]);
      end
      tick();
    end
    tests++; if (pvld[1] !== 1'b1 || pd[15:8] !== 8'h11) begin fails++; $display("FAIL bp_head got=%b/%h exp=1/11", pvld[1], pd[15:8]); end
    prdy = 2'b10; #1;
    tests++; if (wen_comp[1] !== 1'b0) begin fails++; $display("FAIL bp_full_pop_wen got=%b exp=0", wen_comp[1]); end
    tick();
    tests++; if (wen_comp[1] !== 1'b1 || bawt[1] !== 1'b1) begin
      fails++; $display("FAIL bp_accept33 wen/bawt got=%b/%b exp=1/1", wen_comp[1], bawt[1]);
    end
    tests++; if (pd[15:8] !== 8'h22) begin fails++; $display("FAIL bp_order2 got=%h exp=22", pd[15:8]); end
    tick();
    oswt = 2'b00; #1;
    tests++; if (pvld[1] !== 1'b1 || pd[15:8] !== 8'h33) begin fails++; $display("FAIL bp_order3 got=%b/%h exp=1/33", pvld[1], pd[15:8]); end
    tick();
    prdy = 2'b00; #1;
    tests++; if (pvld[1] !== 1'b0) begin fails++; $display("FAIL bp_drained got=%b exp=0", pvld[1]); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] prev;
    bdwt = 1'b1; prdy = 2'b11; oswt = 2'b11;
    for (int k = 0; k < 6; k++) begin
      idat = {8'h80 + 8'(k), 8'h10 + 8'(k)}; #1;
      tests++; if (wen_comp !== 2'b11 || bawt !== 2'b11) begin
        fails++; $display("FAIL b2b_c%0d wen/bawt got=%b/%b exp=11/11", k, wen_comp, bawt);
      end
      if (k > 0) begin
        tests++; if (pvld !== 2'b11 || pd !== prev) begin
          fails++; $display("FAIL b2b_c%0d_out got=%b/%h exp=11/%h", k, pvld, pd, prev);
        end
      end
      prev = idat;
      tick();
    end
    oswt = 2'b00; #1;
    tests++; if (pvld !== 2'b11 || pd !== 16'h8515) begin fails++; $display("FAIL b2b_last got=%b/%h exp=11/8515", pvld, pd); end
    tick();
    tests++; if (pvld !== 2'b00) begin fails++; $display("FAIL b2b_drained got=%b exp=00", pvld); end
    prdy = 2'b00;
  endtask

  task automatic test_reset_mid_burst();
    bdwt = 1'b1; prdy = 2'b00; oswt = 2'b01;
    idat = 16'h00E1; tick();
    idat = 16'h00E2; tick();
    oswt = 2'b00; #1;
    tests++; if (pvld[0] !== 1'b1 || pd[7:0] !== 8'hE1) begin fails++; $display("FAIL mid_pre got=%b/%h exp=1/e1", pvld[0], pd[7:0]); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (pvld !== 2'b00 || pd !== 16'h0000) begin fails++; $display("FAIL mid_async got=%b/%h exp=00/0000", pvld, pd); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    oswt = 2'b01; idat = 16'h005C; tick();
    oswt = 2'b00; #1;
    tests++; if (pvld[0] !== 1'b1 || pd[7:0] !== 8'h5C) begin fails++; $display("FAIL mid_first got=%b/%h exp=1/5c", pvld[0], pd[7:0]); end
  endtask

`ifdef SDP_CHN_OUT_WAIT_DP_STAT_EN
  task automatic test_stall_stat();
    // ch0 holds 8'h5C; one more write fills it, then 10 stalled cycles.
    bdwt = 1'b1; prdy = 2'b00; oswt = 2'b01; idat = 16'h005D;
    tick();
    repeat (10) tick();
    oswt = 2'b00; #1;
    tests++; if (stall_cnt !== 16'd10) begin fails++; $display("FAIL stat_10 got=%0d exp=10", stall_cnt); end
    oswt = 2'b01;
    repeat (70000) tick();
    oswt = 2'b00; #1;
    tests++; if (stall_cnt !== 16'hFFFF) begin fails++; $display("FAIL stat_sat got=%h exp=ffff", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_completion_hold();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_burst();
`ifdef SDP_CHN_OUT_WAIT_DP_STAT_EN
    test_stall_stat();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sdp_chn_out_wait_dp_mc.md
# sdp_chn_out_wait_dp_mc

Parametrised, multi-channel write-wait datapath for SDP core output channels. It sits between the scheduled SDP compute core and NCHN downstream valid/ready output channels. For each channel it holds a per-channel completion-hold bit, so a write accepted while the core is stalled is remembered until the core advances. Each channel also has a DEPTH-entry output FIFO, which decouples core writes from downstream back-pressure. The single-bit, single-channel, unbuffered wait datapath becomes a special case of this block.

## Interface
- NCHN, 2, number of independent output channels (≥1)
- DW, 32, payload width per channel (≥1)
- DEPTH, 2, FIFO entries per channel (≥1, need not be power of two)
- nvdla_core_clk  in  1  core clock; all state on rising edge
- nvdla_core_rstn  in  1  reset, asynchronous assert, active-low
- chn_out_rsci_oswt  in  NCHN  core requests a write on channel i this cycle
- chn_out_rsci_idat  in  NCHN*DW  write payload; channel i at [i*DW +: DW]
- chn_out_rsci_bdwt  in  1  core advances this cycle (consumes pending completions)
- chn_out_rsci_bawt  out  NCHN  write on channel i is complete (this cycle or held)
- chn_out_rsci_wen_comp  out  NCHN  channel i does not stall the core
- chn_out_pvld  out  NCHN  downstream valid per channel
- chn_out_prdy  in  NCHN  downstream ready per channel
- chn_out_pd  out  NCHN*DW  downstream payload; channel i at [i*DW +: DW]

## Operation
Per channel i, all channels are independent:
- Signal definitions:
  - full = (cnt == DEPTH).
  - push = oswt & ~bcwt & ~full. This is the biwt of the channel: a write is taken this cycle.
  - bawt = push | bcwt.
  - wen_comp = ~oswt | bawt.
- bcwt_next = bawt & ~bdwt. A completion is held until the core advances, and a held completion blocks a second push.
- push writes idat[i] at wptr. pop = pvld & prdy reads rptr.
- Pointers wrap from DEPTH-1 to 0.
- cnt_next = cnt + push - pop. Simultaneous push and pop leaves cnt unchanged.
- Full: push is refused even if pop occurs in the same cycle. There is no prdy→wen_comp combinational path, so wen_comp = 0 while oswt is high.
- Empty: there is no bypass. pvld = (cnt != 0), and pd = mem[rptr] (registered storage).
- cnt width is $clog2(DEPTH+1). cnt never exceeds DEPTH and never underflows, because pop requires pvld.
- Reset (any time, including mid-burst): bcwt = 0, cnt = 0, wptr = rptr = 0, pvld = 0, storage cleared to 0. In-flight entries are discarded.
- Outputs after reset with oswt = 0: bawt = 0, wen_comp = 1, pvld = 0, pd = 0.

## Timing
- bawt and wen_comp are combinational from oswt, bcwt and cnt. They have no dependence on prdy or bdwt.
- Write-to-pvld latency is 1 cycle: push in cycle t gives pvld at t+1 when the FIFO was empty.
- Downstream throughput is 1 entry/cycle/channel with prdy held high.
- Completion hold: a push in cycle t with bdwt = 0 keeps bawt = 1 in t+1 through to the cycle in which bdwt = 1. bcwt clears on the edge after that cycle.
- pvld is held until prdy, and pd is stable while pvld & ~prdy.

## Configuration
- SDP_CHN_OUT_WAIT_DP_STAT_EN defined: adds output chn_out_stall_cnt, 16 bits.
  - It increments once per cycle in which any channel has oswt & ~wen_comp.
  - It saturates at 16'hFFFF and resets to 0.
- Not defined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Package sdp_chn_out_wait_pkg holds:
  - Default NCHN, DW and DEPTH constants.
  - STAT_W = 16.
  - The count-width helper, returning $clog2(DEPTH+1).
- Sub-module sdp_chn_out_fifo: a single-channel DEPTH x DW FIFO with push/pop, cnt, pvld and pd, instantiated NCHN times in a generate loop.
- The top level holds only the bcwt flops, the handshake logic, lane slicing and the optional stat counter.

## Test plan
Bench configuration: NCHN=2, DW=8, DEPTH=2 unless noted.
- Reset release, all oswt=0 -> bawt=2'b00, wen_comp=2'b11, pvld=2'b00, pd=16'h0000.
- ch0 oswt=1, idat=8'hA5, bdwt=0 for 3 cycles, then bdwt=1 -> exactly one push, bawt[0]=1 for all 4 cycles, pvld[0]=1 from cycle 2 with pd=8'hA5, bcwt clear after bdwt.
- ch1 prdy=0, write 8'h11, 8'h22 (bdwt=1 each), third write 8'h33 -> wen_comp[1]=0 until prdy=1 pops 8'h11; 8'h33 is accepted on the following cycle, and order 11,22,33 is preserved.
- Both channels writing every cycle, bdwt=1, prdy=1 -> 1 entry/cycle/channel, cnt stays at 1, no stalls.
- Reset asserted with ch0 cnt=2 -> pvld[0] drops to 0 asynchronously, and after release the first new write 8'h5C is the first data out.
- With SDP_CHN_OUT_WAIT_DP_STAT_EN defined, hold ch0 full for 10 cycles with oswt=1 -> chn_out_stall_cnt=10. Force 70000 stall cycles -> chn_out_stall_cnt=16'hFFFF.
